// File: rtl/post_box_pkg.sv
// Shared types and constants for the POST-box USB bridge.
// The SPI status and request bytes carry their flags in the two LSBs.
package post_box_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_IN_DATA,
        ST_IN_CHAIN,
        ST_DEAD,
        ST_OUT_DATA
    } pb_state_e;

    localparam int CMD_OUTPUT = 3;
    localparam int CMD_INPUT  = 4;

    // Bit positions inside SPI byte 0: DUT status and master request.
    localparam int STAT_RXFULL_BIT    = 1;
    localparam int STAT_TXSPACE_BIT   = 0;
    localparam int REQ_HAVE_BYTE_BIT  = 1;
    localparam int REQ_HAVE_SPACE_BIT = 0;

    localparam int SPI_FRAME_BITS = 16;

endpackage

// File: rtl/post_box_spi_slave.sv
// Oversampled SPI mode-0 slave, one 16-bit frame per CS assertion.
// Status is snapshotted at CS fall; commit strobes fire on CS rise after exactly 16 bits.
module post_box_spi_slave
    import post_box_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       spi_cs_i,
    input  logic       spi_sck_i,
    input  logic       spi_mosi_i,
    output logic       spi_miso_o,
    input  logic       rxfull_i,
    input  logic       txfull_i,
    input  logic [7:0] rx_data_i,
    output logic       tx_wr_o,
    output logic [7:0] tx_data_o,
    output logic       rx_clr_o
);

    logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, mosi_sync_q;
    logic                   cs_prev_q, sck_prev_q;
    logic [9:0]             in_sr_q, in_sr_d;
    logic [15:0]            out_sr_q, out_sr_d;
    logic [4:0]             bits_q, bits_d;
    logic                   snap_rxfull_q, snap_rxfull_d;
    logic                   snap_space_q, snap_space_d;
    logic                   miso_q, miso_d;

    logic cs_s, sck_s, mosi_s;
    logic cs_fall, cs_rise, sck_rise, sck_fall, frame_ok;
    logic [7:0] status_byte;

    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign cs_fall  = cs_prev_q & ~cs_s;
    assign cs_rise  = ~cs_prev_q & cs_s;
    assign sck_rise = ~cs_s & sck_s & ~sck_prev_q;
    assign sck_fall = ~cs_s & ~sck_s & sck_prev_q;

    always_comb begin
        status_byte                   = 8'h00;
        status_byte[STAT_RXFULL_BIT]  = rxfull_i;
        status_byte[STAT_TXSPACE_BIT] = ~txfull_i;
    end

    always_comb begin
        in_sr_d       = in_sr_q;
        out_sr_d      = out_sr_q;
        bits_d        = bits_q;
        snap_rxfull_d = snap_rxfull_q;
        snap_space_d  = snap_space_q;
        if (cs_fall) begin
            out_sr_d      = {status_byte, rxfull_i ? rx_data_i : 8'h00};
            bits_d        = 5'd0;
            snap_rxfull_d = rxfull_i;
            snap_space_d  = ~txfull_i;
        end
        if (sck_rise) begin
            in_sr_d = {in_sr_q[8:0], mosi_s};
            if (bits_q != 5'd31) begin
                bits_d = bits_q + 5'd1;
            end
        end
        if (sck_fall) begin
            out_sr_d = {out_sr_q[14:0], 1'b0};
        end
        miso_d = cs_s ? 1'b0 : out_sr_d[15];
    end

    assign frame_ok   = cs_rise && (bits_q == 5'(SPI_FRAME_BITS));
    assign tx_wr_o    = frame_ok & in_sr_q[8 + REQ_HAVE_BYTE_BIT] & snap_space_q;
    assign rx_clr_o   = frame_ok & in_sr_q[8 + REQ_HAVE_SPACE_BIT] & snap_rxfull_q;
    assign tx_data_o  = in_sr_q[7:0];
    assign spi_miso_o = miso_q;

    // CS resets to its idle (high) level so reset release never looks like a frame start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cs_sync_q     <= '1;
            sck_sync_q    <= '0;
            mosi_sync_q   <= '0;
            cs_prev_q     <= 1'b1;
            sck_prev_q    <= 1'b0;
            in_sr_q       <= '0;
            out_sr_q      <= '0;
            bits_q        <= '0;
            snap_rxfull_q <= 1'b0;
            snap_space_q  <= 1'b0;
            miso_q        <= 1'b0;
        end else begin
            cs_sync_q     <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_i};
            sck_sync_q    <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck_i};
            mosi_sync_q   <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
            cs_prev_q     <= cs_s;
            sck_prev_q    <= sck_s;
            in_sr_q       <= in_sr_d;
            out_sr_q      <= out_sr_d;
            bits_q        <= bits_d;
            snap_rxfull_q <= snap_rxfull_d;
            snap_space_q  <= snap_space_d;
            miso_q        <= miso_d;
        end
    end

endmodule

// File: rtl/post_box_usb_bridge.sv
// Acorn POST-box adapter: decodes testreq pulse groups, answers with testack,
// and exchanges single bytes with a USB-side SPI master through 1-byte RX/TX buffers.
module post_box_usb_bridge
    import post_box_pkg::*;
#(
    parameter int BREAK_CYCLES = 480,
    parameter int SYNC_STAGES  = 2
) (
    input  logic fpga_clock_48mhz,
    input  logic fpga_reset_n,
    input  logic reset_in,
    input  logic target_power_3v,
    output logic target_power_out,
    input  logic fpga_spi_cs,
    input  logic fpga_spi_sck,
    input  logic fpga_spi_mosi,
    output logic fpga_spi_miso,
    input  logic testreq_3v,
    output logic testack_noe,
    output logic target_reset_noe,
    output logic hotswap_noe
);

    localparam int GAP_W = $clog2(BREAK_CYCLES + 1);

    logic [SYNC_STAGES-1:0] req_sync_q, pwr_sync_q, rst_sync_q;
    logic req_s, pwr_s, rst_s;
    logic req_prev_q;

    pb_state_e  state_q, state_d;
    logic [2:0] n_q, n_d, n_inc;
    logic       ack3_q, ack3_d;
    logic       ack_q, ack_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [1:0] grp_q, grp_d;
    logic       armed_q, armed_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [7:0] tx_q, tx_d, rx_q, rx_d;
    logic       txfull_q, txfull_d, rxfull_q, rxfull_d;

    logic req_rise, req_fall, brk, take, store;
    logic [7:0] out_byte;
    logic       spi_tx_wr, spi_rx_clr;
    logic [7:0] spi_tx_data;

    assign req_s = req_sync_q[SYNC_STAGES-1];
    assign pwr_s = pwr_sync_q[SYNC_STAGES-1];
    assign rst_s = rst_sync_q[SYNC_STAGES-1];

    assign req_rise = req_s & ~req_prev_q;
    assign req_fall = ~req_s & req_prev_q;
    // A break only counts once per pulse group, so a long idle line fires nothing.
    assign brk      = armed_q & ~req_s & (gap_q == GAP_W'(BREAK_CYCLES - 1));
    assign n_inc    = n_q + 3'd1;
    assign out_byte = {shreg_q[6:0], grp_q == 2'd2};

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        ack3_d   = ack3_q;
        ack_d    = req_fall ? 1'b0 : ack_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        grp_d    = grp_q;
        take     = 1'b0;
        store    = 1'b0;
        gap_d    = req_s ? '0 : ((gap_q == GAP_W'(BREAK_CYCLES)) ? gap_q : gap_q + GAP_W'(1));
        armed_d  = req_rise ? 1'b1 : (brk ? 1'b0 : armed_q);

        if (!pwr_s) begin
            state_d = ST_IDLE;
            ack_d   = 1'b0;
            armed_d = 1'b0;
            n_d     = '0;
            grp_d   = '0;
        end else if (req_rise) begin
            ack_d = 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    n_d     = 3'd1;
                    ack3_d  = 1'b0;
                    state_d = ST_CMD;
                end
                ST_CMD: begin
                    n_d = n_inc;
                    if (n_inc == 3'(CMD_OUTPUT)) begin
                        ack_d  = ~rxfull_q;
                        ack3_d = ~rxfull_q;
                    end else if (n_inc == 3'(CMD_INPUT)) begin
                        if (txfull_q) begin
                            ack_d    = 1'b1;
                            take     = 1'b1;
                            shreg_d  = tx_q;
                            bitcnt_d = '0;
                            state_d  = ST_IN_DATA;
                        end else begin
                            state_d = ST_DEAD;
                        end
                    end
                end
                ST_IN_DATA: begin
                    ack_d    = shreg_q[7];
                    shreg_d  = {shreg_q[6:0], 1'b0};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = ST_IN_CHAIN;
                    end
                end
                ST_IN_CHAIN: begin
                    if (txfull_q) begin
                        ack_d    = 1'b1;
                        take     = 1'b1;
                        shreg_d  = tx_q;
                        bitcnt_d = '0;
                        state_d  = ST_IN_DATA;
                    end else begin
                        state_d = ST_DEAD;
                    end
                end
                ST_OUT_DATA: begin
                    if (grp_q != 2'd3) begin
                        grp_d = grp_q + 2'd1;
                    end
                end
                default: ;
            endcase
        end else if (brk) begin
            state_d = ST_IDLE;
            grp_d   = '0;
            if (state_q == ST_CMD && n_q == 3'(CMD_OUTPUT) && ack3_q) begin
                state_d  = ST_OUT_DATA;
                bitcnt_d = '0;
            end else if (state_q == ST_OUT_DATA && (grp_q == 2'd1 || grp_q == 2'd2)) begin
                // One pulse encodes 0, two pulses encode 1; the eighth group completes the byte.
                shreg_d  = out_byte;
                bitcnt_d = bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) begin
                    store = 1'b1;
                end else begin
                    state_d = ST_OUT_DATA;
                end
            end
        end

        // The target only clears txfull and only sets rxfull, so both sides may act in one clock.
        txfull_d = (txfull_q & ~take) | spi_tx_wr;
        tx_d     = spi_tx_wr ? spi_tx_data : tx_q;
        rxfull_d = (rxfull_q & ~spi_rx_clr) | store;
        rx_d     = store ? out_byte : rx_q;
    end

    always_ff @(posedge fpga_clock_48mhz or negedge fpga_reset_n) begin
        if (!fpga_reset_n) begin
            req_sync_q <= '0;
            pwr_sync_q <= '0;
            rst_sync_q <= '0;
            req_prev_q <= 1'b0;
            state_q    <= ST_IDLE;
            n_q        <= '0;
            ack3_q     <= 1'b0;
            ack_q      <= 1'b0;
            shreg_q    <= '0;
            bitcnt_q   <= '0;
            grp_q      <= '0;
            armed_q    <= 1'b0;
            gap_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            txfull_q   <= 1'b0;
            rxfull_q   <= 1'b0;
        end else begin
            req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], testreq_3v};
            pwr_sync_q <= {pwr_sync_q[SYNC_STAGES-2:0], target_power_3v};
            rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], reset_in};
            req_prev_q <= req_s;
            state_q    <= state_d;
            n_q        <= n_d;
            ack3_q     <= ack3_d;
            ack_q      <= ack_d;
            shreg_q    <= shreg_d;
            bitcnt_q   <= bitcnt_d;
            grp_q      <= grp_d;
            armed_q    <= armed_d;
            gap_q      <= gap_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            txfull_q   <= txfull_d;
            rxfull_q   <= rxfull_d;
        end
    end

    post_box_spi_slave #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_spi (
        .clk_i      (fpga_clock_48mhz),
        .rst_ni     (fpga_reset_n),
        .spi_cs_i   (fpga_spi_cs),
        .spi_sck_i  (fpga_spi_sck),
        .spi_mosi_i (fpga_spi_mosi),
        .spi_miso_o (fpga_spi_miso),
        .rxfull_i   (rxfull_q),
        .txfull_i   (txfull_q),
        .rx_data_i  (rx_q),
        .tx_wr_o    (spi_tx_wr),
        .tx_data_o  (spi_tx_data),
        .rx_clr_o   (spi_rx_clr)
    );

    assign testack_noe      = ~ack_q;
    assign target_reset_noe = ~rst_s;
    assign hotswap_noe      = 1'b1;
    assign target_power_out = pwr_s;

endmodule

// File: tb/tb_post_box_usb_bridge.sv
// Directed bench for the POST-box bridge: drives testreq pulse groups and SPI frames,
// compares testack and SPI replies against hand-computed values.
module tb_post_box_usb_bridge;

    localparam int BREAK_CYCLES = 480;
    localparam int SCK_HALF     = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic reset_in = 1'b0;
    logic power = 1'b1;
    logic power_out;
    logic cs = 1'b1, sck = 1'b0, mosi = 1'b0, miso;
    logic testreq = 1'b0;
    logic testack_noe, target_reset_noe, hotswap_noe;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    post_box_usb_bridge #(
        .BREAK_CYCLES (BREAK_CYCLES),
        .SYNC_STAGES  (2)
    ) dut (
        .fpga_clock_48mhz (clk),
        .fpga_reset_n     (rst_n),
        .reset_in         (reset_in),
        .target_power_3v  (power),
        .target_power_out (power_out),
        .fpga_spi_cs      (cs),
        .fpga_spi_sck     (sck),
        .fpga_spi_mosi    (mosi),
        .fpga_spi_miso    (miso),
        .testreq_3v       (testreq),
        .testack_noe      (testack_noe),
        .target_reset_noe (target_reset_noe),
        .hotswap_noe      (hotswap_noe)
    );

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One testreq pulse; reports ack seen mid-pulse and whether it was released after the fall.
    task automatic pulse(output logic ack_seen, output logic released);
        testreq = 1'b1;
        wait_clk(6);
        ack_seen = ~testack_noe;
        wait_clk(2);
        testreq = 1'b0;
        wait_clk(24);
        released = testack_noe;
    endtask

    task automatic brk();
        wait_clk(BREAK_CYCLES + 40);
    endtask

    task automatic spi_xfer(input logic [1:0] flags, input logic [7:0] data, input int nbits,
                            output logic [7:0] stat, output logic [7:0] rdata);
        logic [15:0] mo, mi;
        mo = {6'b0, flags, data};
        mi = '0;
        cs = 1'b0;
        wait_clk(8);
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[15-i];
            wait_clk(SCK_HALF);
            sck = 1'b1;
            mi[15-i] = miso;
            wait_clk(SCK_HALF);
            sck = 1'b0;
        end
        wait_clk(4);
        cs = 1'b1;
        mosi = 1'b0;
        wait_clk(8);
        stat  = mi[15:8];
        rdata = mi[7:0];
    endtask

    task automatic test_reset();
        wait_clk(3);
        checks++;
        if ({testack_noe, target_reset_noe, hotswap_noe, miso, power_out} !== 5'b11100) begin
            errors++;
            $display("FAIL reset_outputs: got ack_noe/rst_noe/hs_noe/miso/pwr=%b required 11100",
                     {testack_noe, target_reset_noe, hotswap_noe, miso, power_out});
        end
        rst_n = 1'b1;
        wait_clk(6);
        checks++;
        if ({testack_noe, target_reset_noe, hotswap_noe, miso, power_out} !== 5'b11101) begin
            errors++;
            $display("FAIL after_reset_outputs: got %b required 11101",
                     {testack_noe, target_reset_noe, hotswap_noe, miso, power_out});
        end
        reset_in = 1'b1;
        wait_clk(5);
        checks++;
        if (target_reset_noe !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_assert: target_reset_noe=%b required 0", target_reset_noe);
        end
        reset_in = 1'b0;
        wait_clk(5);
        checks++;
        if (target_reset_noe !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_release: target_reset_noe=%b required 1", target_reset_noe);
        end
        $display("test_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_idle_probe();
        logic a, r;
        logic [3:0] exp;
        logic [7:0] st, rd;
        exp = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            pulse(a, r);
            checks++;
            if ({a, r} !== {exp[3-i], 1'b1}) begin
                errors++;
                $display("FAIL probe_ack pulse %0d: ack=%b released=%b required ack=%b", i + 1, a, r, exp[3-i]);
            end
        end
        brk();
        spi_xfer(2'b01, 8'h00, 16, st, rd);
        checks++;
        if ({st, rd} !== 16'h0100) begin
            errors++;
            $display("FAIL probe_spi: status=%h data=%h required 01 00", st, rd);
        end
        $display("test_idle_probe done: status=%h data=%h", st, rd);
    endtask

    task automatic test_rx_path();
        logic a, r;
        logic [2:0] exp3;
        logic [7:0] byte_out, st, rd;
        exp3 = 3'b001;
        for (int i = 0; i < 3; i++) begin
            pulse(a, r);
            checks++;
            if ({a, r} !== {exp3[2-i], 1'b1}) begin
                errors++;
                $display("FAIL out_cmd_ack pulse %0d: ack=%b required %b", i + 1, a, exp3[2-i]);
            end
        end
        brk();
        byte_out = 8'hA8;
        for (int b = 7; b >= 0; b--) begin
            for (int p = 0; p < (byte_out[b] ? 2 : 1); p++) begin
                pulse(a, r);
                checks++;
                if (a !== 1'b0) begin
                    errors++;
                    $display("FAIL out_bit_noack bit %0d: ack=%b required 0", b, a);
                end
            end
            brk();
        end
        for (int i = 0; i < 3; i++) begin
            pulse(a, r);
            checks++;
            if (a !== 1'b0) begin
                errors++;
                $display("FAIL rxfull_cmd3 pulse %0d: ack=%b required 0", i + 1, a);
            end
        end
        brk();
        for (int k = 0; k < 2; k++) begin
            spi_xfer(2'b00, 8'h00, 16, st, rd);
            checks++;
            if ({st, rd} !== 16'h03A8) begin
                errors++;
                $display("FAIL rx_peek %0d: status=%h data=%h required 03 a8", k, st, rd);
            end
        end
        spi_xfer(2'b01, 8'h00, 16, st, rd);
        checks++;
        if ({st, rd} !== 16'h03A8) begin
            errors++;
            $display("FAIL rx_take: status=%h data=%h required 03 a8", st, rd);
        end
        spi_xfer(2'b00, 8'h00, 16, st, rd);
        checks++;
        if ({st, rd} !== 16'h0100) begin
            errors++;
            $display("FAIL rx_cleared: status=%h data=%h required 01 00", st, rd);
        end
        $display("test_rx_path done: last status=%h data=%h", st, rd);
    endtask

    task automatic test_tx_flow();
        logic a, r;
        logic [3:0] exp4;
        logic [11:0] exp;
        logic [7:0] st, rd;
        logic [7:0] bytes [3];
        exp4 = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            pulse(a, r);
            checks++;
            if (a !== exp4[3-i]) begin
                errors++;
                $display("FAIL empty_tx_ack pulse %0d: ack=%b required %b", i + 1, a, exp4[3-i]);
            end
        end
        brk();
        spi_xfer(2'b11, 8'h5A, 16, st, rd);
        checks++;
        if (st !== 8'h01) begin
            errors++;
            $display("FAIL tx_accept: status=%h required 01", st);
        end
        spi_xfer(2'b11, 8'h99, 16, st, rd);
        checks++;
        if (st !== 8'h00) begin
            errors++;
            $display("FAIL tx_reject: status=%h required 00", st);
        end
        bytes[0] = 8'h5A;
        bytes[1] = 8'h42;
        bytes[2] = 8'hC3;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                spi_xfer(2'b11, bytes[k], 16, st, rd);
                checks++;
                if (st !== 8'h01) begin
                    errors++;
                    $display("FAIL tx_accept_%0d: status=%h required 01", k, st);
                end
            end
            exp = {4'b0011, bytes[k]};
            for (int i = 0; i < 12; i++) begin
                pulse(a, r);
                checks++;
                if ({a, r} !== {exp[11-i], 1'b1}) begin
                    errors++;
                    $display("FAIL in_byte_%h pulse %0d: ack=%b released=%b required ack=%b",
                             bytes[k], i + 1, a, r, exp[11-i]);
                end
            end
            brk();
            $display("test_tx_flow byte %h read by target", bytes[k]);
        end
    endtask

    task automatic test_chain();
        logic a, r;
        logic [11:0] exp;
        logic [8:0] exp9;
        logic [7:0] st, rd;
        logic [7:0] bytes [3];
        bytes[0] = 8'h12;
        bytes[1] = 8'hFF;
        bytes[2] = 8'h34;
        for (int k = 0; k < 3; k++) begin
            spi_xfer(2'b10, bytes[k], 16, st, rd);
            checks++;
            if (st !== 8'h01) begin
                errors++;
                $display("FAIL chain_accept_%0d: status=%h required 01", k, st);
            end
            if (k == 0) begin
                exp = {4'b0011, bytes[k]};
                for (int i = 0; i < 12; i++) begin
                    pulse(a, r);
                    checks++;
                    if (a !== exp[11-i]) begin
                        errors++;
                        $display("FAIL chain_first pulse %0d: ack=%b required %b", i + 1, a, exp[11-i]);
                    end
                end
            end else begin
                exp9 = {1'b1, bytes[k]};
                for (int i = 0; i < 9; i++) begin
                    pulse(a, r);
                    checks++;
                    if (a !== exp9[8-i]) begin
                        errors++;
                        $display("FAIL chain_%h pulse %0d: ack=%b required %b", bytes[k], i + 1, a, exp9[8-i]);
                    end
                end
            end
        end
        pulse(a, r);
        checks++;
        if (a !== 1'b0) begin
            errors++;
            $display("FAIL chain_empty: ack=%b required 0", a);
        end
        brk();
        $display("test_chain done");
    endtask

    task automatic test_abort_and_power();
        logic a, r;
        logic [2:0] exp3;
        logic [7:0] st, rd;
        spi_xfer(2'b11, 8'h77, 15, st, rd);
        spi_xfer(2'b00, 8'h00, 16, st, rd);
        checks++;
        if ({st, rd} !== 16'h0100) begin
            errors++;
            $display("FAIL short_frame: status=%h data=%h required 01 00", st, rd);
        end
        exp3 = 3'b001;
        for (int i = 0; i < 3; i++) begin
            pulse(a, r);
        end
        brk();
        pulse(a, r);
        pulse(a, r);
        brk();
        power = 1'b0;
        wait_clk(10);
        checks++;
        if ({power_out, testack_noe} !== 2'b01) begin
            errors++;
            $display("FAIL power_low: power_out=%b ack_noe=%b required 0 1", power_out, testack_noe);
        end
        power = 1'b1;
        wait_clk(10);
        for (int i = 0; i < 3; i++) begin
            pulse(a, r);
            checks++;
            if (a !== exp3[2-i]) begin
                errors++;
                $display("FAIL power_restart pulse %0d: ack=%b required %b", i + 1, a, exp3[2-i]);
            end
        end
        brk();
        $display("test_abort_and_power done");
    endtask

    initial begin
        test_reset();
        test_idle_probe();
        test_rx_path();
        test_tx_flow();
        test_chain();
        test_abort_and_power();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
